// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU (A) and load return (M).
// Optional R0_WRITE_PROTECT_EN: writes to register 0 keep timing but never strobe load_enable.
module regfile_write_arbiter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  a_valid,
  input  logic [3:0]            a_dest,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  m_valid,
  input  logic [3:0]            m_dest,
  input  logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_ready,
  output logic [3:0]            decoder_control,
  output logic                  load_enable,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  busy
);

  localparam int unsigned DEST_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  ptr_q, ptr_d;  // 0: A has priority, 1: M has priority
  logic [DEST_W-1:0]     ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  le_q, le_d;
  logic                  busy_q, busy_d;

  logic can_accept;
  logic grant_a;
  logic grant_m;
  logic strobe_allowed;

  // Handshake and round-robin grant; nothing is accepted while reset is asserted
  always_comb begin
    can_accept = reset_n && ((state_q == IDLE) || (state_q == STROBE));
    grant_a    = can_accept && a_valid && (!m_valid || !ptr_q);
    grant_m    = can_accept && m_valid && (!a_valid || ptr_q);
  end

  assign a_ready = grant_a;
  assign m_ready = grant_m;

`ifdef R0_WRITE_PROTECT_EN
  assign strobe_allowed = (ctrl_q != DEST_W'(0));
`else
  assign strobe_allowed = 1'b1;
`endif

  // Next-state, latch and registered-output logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    le_d    = 1'b0;
    busy_d  = 1'b0;

    unique case (state_q)
      IDLE:    if (grant_a || grant_m) state_d = SETUP;
      SETUP:   state_d = STROBE;
      STROBE:  state_d = (grant_a || grant_m) ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase

    if (grant_a) begin
      ctrl_d = a_dest;
      data_d = a_data;
    end else if (grant_m) begin
      ctrl_d = m_dest;
      data_d = m_data;
    end

    // Pointer only moves when both requesters competed for the grant
    if (can_accept && a_valid && m_valid) ptr_d = ~ptr_q;

    le_d   = (state_d == STROBE) && strobe_allowed;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
      le_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      le_q    <= le_d;
      busy_q  <= busy_d;
    end
  end

  assign decoder_control = ctrl_q;
  assign write_data      = data_q;
  assign load_enable     = le_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter; honours R0_WRITE_PROTECT_EN when defined.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_valid, m_valid;
  logic [3:0]  a_dest, m_dest;
  logic [31:0] a_data, m_data;
  logic        a_ready, m_ready;
  logic [3:0]  decoder_control;
  logic        load_enable;
  logic [31:0] write_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter #(.DATA_WIDTH(32)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .a_valid         (a_valid),
    .a_dest          (a_dest),
    .a_data          (a_data),
    .a_ready         (a_ready),
    .m_valid         (m_valid),
    .m_dest          (m_dest),
    .m_data          (m_data),
    .m_ready         (m_ready),
    .decoder_control (decoder_control),
    .load_enable     (load_enable),
    .write_data      (write_data),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    logic exp_le;

    reset_n = 1'b0;
    a_valid = 1'b1; a_dest = 4'd5; a_data = 32'h1234;
    m_valid = 1'b0; m_dest = 4'd0; m_data = 32'h0;

    // Reset held three cycles with a pending request
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_a_ready_%0d", i), 32'(a_ready), 32'd0);
      chk($sformatf("rst_le_%0d", i), 32'(load_enable), 32'd0);
      chk($sformatf("rst_ctrl_%0d", i), 32'(decoder_control), 32'd0);
      chk($sformatf("rst_busy_%0d", i), 32'(busy), 32'd0);
      chk($sformatf("rst_wdata_%0d", i), write_data, 32'd0);
    end

    // Single write: accept in cycle N
    reset_n = 1'b1;
    #1;
    chk("single_a_ready_N", 32'(a_ready), 32'd1);
    chk("single_m_ready_N", 32'(m_ready), 32'd0);
    tick();
    a_valid = 1'b0;
    #1;
    chk("single_ctrl_N1", 32'(decoder_control), 32'd5);
    chk("single_wdata_N1", write_data, 32'h1234);
    chk("single_le_N1", 32'(load_enable), 32'd0);
    chk("single_busy_N1", 32'(busy), 32'd1);
    chk("single_a_ready_N1", 32'(a_ready), 32'd0);
    tick();
    chk("single_le_N2", 32'(load_enable), 32'd1);
    chk("single_ctrl_N2", 32'(decoder_control), 32'd5);
    chk("single_busy_N2", 32'(busy), 32'd1);
    tick();
    chk("single_le_N3", 32'(load_enable), 32'd0);
    chk("single_busy_N3", 32'(busy), 32'd0);

    // Contention: A has priority after a single-source grant
    a_valid = 1'b1; a_dest = 4'd3; a_data = 32'hA3;
    m_valid = 1'b1; m_dest = 4'd9; m_data = 32'h99;
    #1;
    chk("cont_a_ready_c0", 32'(a_ready), 32'd1);
    chk("cont_m_ready_c0", 32'(m_ready), 32'd0);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 6) begin
        a_valid = 1'b0;
        m_valid = 1'b0;
      end
      #1;
      chk($sformatf("cont_ctrl_c%0d", c), 32'(decoder_control),
          (c == 3 || c == 4) ? 32'd9 : 32'd3);
      chk($sformatf("cont_le_c%0d", c), 32'(load_enable), 32'((c % 2) == 0));
      chk($sformatf("cont_a_ready_c%0d", c), 32'(a_ready), 32'(c == 4));
      chk($sformatf("cont_m_ready_c%0d", c), 32'(m_ready), 32'(c == 2));
    end
    tick();
    chk("cont_idle_busy", 32'(busy), 32'd0);
    chk("cont_idle_le", 32'(load_enable), 32'd0);

    // Back-to-back from M: four requests with dest 1..4
    pulses = 0;
    for (int c = 0; c <= 9; c++) begin
      m_valid = (c <= 6);
      m_dest  = 4'((c + 1) / 2 + 1);
      m_data  = 32'h100 + 32'((c + 1) / 2 + 1);
      #1;
      chk($sformatf("b2b_m_ready_c%0d", c), 32'(m_ready), 32'(c <= 6 && (c % 2) == 0));
      exp_le = (c >= 2) && (c <= 8) && ((c % 2) == 0);
      chk($sformatf("b2b_le_c%0d", c), 32'(load_enable), 32'(exp_le));
      if (load_enable) pulses++;
      if (exp_le) begin
        chk($sformatf("b2b_ctrl_c%0d", c), 32'(decoder_control), 32'(c / 2));
        chk($sformatf("b2b_wdata_c%0d", c), write_data, 32'h100 + 32'(c / 2));
      end
      tick();
    end
    chk("b2b_pulse_count", 32'(pulses), 32'd4);
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    m_valid = 1'b0;

    // Reset asserted during SETUP abandons the write
    a_valid = 1'b1; a_dest = 4'd7; a_data = 32'h77;
    #1;
    chk("rmid_a_ready", 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rmid_ctrl_setup", 32'(decoder_control), 32'd7);
    chk("rmid_busy_setup", 32'(busy), 32'd1);
    tick();
    reset_n = 1'b1;
    #1;
    chk("rmid_le", 32'(load_enable), 32'd0);
    chk("rmid_ctrl", 32'(decoder_control), 32'd0);
    chk("rmid_wdata", write_data, 32'd0);
    chk("rmid_busy", 32'(busy), 32'd0);
    tick();
    chk("rmid_le_after", 32'(load_enable), 32'd0);
    chk("rmid_busy_after", 32'(busy), 32'd0);

    // Write to register 0
    a_valid = 1'b1; a_dest = 4'd0; a_data = 32'hDEAD;
    #1;
    chk("r0_a_ready", 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0;
    #1;
    chk("r0_busy_setup", 32'(busy), 32'd1);
    chk("r0_le_setup", 32'(load_enable), 32'd0);
    chk("r0_ctrl_setup", 32'(decoder_control), 32'd0);
    tick();
    chk("r0_busy_strobe", 32'(busy), 32'd1);
`ifdef R0_WRITE_PROTECT_EN
    chk("r0_le_strobe", 32'(load_enable), 32'd0);
`else
    chk("r0_le_strobe", 32'(load_enable), 32'd1);
`endif
    chk("r0_ctrl_strobe", 32'(decoder_control), 32'd0);
    chk("r0_wdata_strobe", write_data, 32'hDEAD);
    tick();
    chk("r0_busy_after", 32'(busy), 32'd0);
    chk("r0_le_after", 32'(load_enable), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
